// File: rtl/maze_pkg.sv
// Shared encodings for the maze datapath: moves, error codes, checker states and cell content.
// The rat and the replay checker both import this package so the stream format stays in one place.
package maze_pkg;

  typedef enum logic [1:0] {
    MV_UP    = 2'b00,
    MV_RIGHT = 2'b01,
    MV_LEFT  = 2'b10,
    MV_DOWN  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    ERR_OOB    = 2'b00,
    ERR_WALL   = 2'b01,
    ERR_OVF    = 2'b10,
    ERR_NOGOAL = 2'b11
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } chk_state_t;

  localparam logic CELL_WALL = 1'b1;
  localparam logic CELL_OPEN = 1'b0;

endpackage

// File: rtl/maze_step.sv
// Combinational single step: applies one move to a position, one bit wider than the
// coordinate so that both underflow below 0 and overflow past the edge show up in the top bit.
module maze_step
  import maze_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] pos_x,
  input  logic [ADDR_W-1:0] pos_y,
  input  logic [1:0]        move,
  output logic [ADDR_W-1:0] next_x,
  output logic [ADDR_W-1:0] next_y,
  output logic              oob
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0] ext_x;
  logic [ADDR_W:0] ext_y;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ext_x = {1'b0, pos_x};
    ext_y = {1'b0, pos_y};
    case (move_t'(move))
      MV_UP:    ext_y = {1'b0, pos_y} - ONE;
      MV_RIGHT: ext_x = {1'b0, pos_x} + ONE;
      MV_LEFT:  ext_x = {1'b0, pos_x} - ONE;
      MV_DOWN:  ext_y = {1'b0, pos_y} + ONE;
      default:  ;
    endcase
  end

  // -1 wraps to all ones and max+1 carries out; either way the extra bit is set.
  assign oob    = ext_x[ADDR_W] | ext_y[ADDR_W];
  assign next_x = ext_x[ADDR_W-1:0];
  assign next_y = ext_y[ADDR_W-1:0];

endmodule

// File: rtl/path_replay_checker.sv
// Replays the rat's move stream from the start cell, checks every step against the maze
// through a private read port, and reports success or the first failure.
module path_replay_checker
  import maze_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int GOAL_X    = 15,
  parameter int GOAL_Y    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              move_valid,
  input  logic [1:0]        move,
  input  logic              move_last,
  output logic              move_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_x,
  output logic [ADDR_W-1:0] rd_y,
  input  logic              rd_data,
  output logic [ADDR_W-1:0] pos_x,
  output logic [ADDR_W-1:0] pos_y,
  output logic [STEP_W-1:0] step_count,
  output logic              ok,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] START_XV = ADDR_W'(START_X);
  localparam logic [ADDR_W-1:0] START_YV = ADDR_W'(START_Y);
  localparam logic [ADDR_W-1:0] GOAL_XV  = ADDR_W'(GOAL_X);
  localparam logic [ADDR_W-1:0] GOAL_YV  = ADDR_W'(GOAL_Y);
  localparam logic [STEP_W:0]   MAX_EXT  = (STEP_W+1)'(MAX_STEPS);
  localparam logic [STEP_W-1:0] MAX_SAT  = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W:0]   STEP_ONE = (STEP_W+1)'(1);

  chk_state_t state, state_d;

  logic [ADDR_W-1:0] pos_x_d, pos_y_d;
  logic [ADDR_W-1:0] nxt_x, nxt_y, nxt_x_d, nxt_y_d;
  logic [ADDR_W-1:0] step_x, step_y;
  logic              step_oob;
  logic              last_q, last_d;
  logic [STEP_W-1:0] step_count_d;
  logic [STEP_W:0]   count_inc;
  logic              ok_d, err_d;
  logic [1:0]        err_code_d;

  maze_step #(.ADDR_W(ADDR_W)) u_step (
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .move   (move),
    .next_x (step_x),
    .next_y (step_y),
    .oob    (step_oob)
  );

  assign count_inc = {1'b0, step_count} + STEP_ONE;

  always_comb begin
    state_d      = state;
    pos_x_d      = pos_x;
    pos_y_d      = pos_y;
    nxt_x_d      = nxt_x;
    nxt_y_d      = nxt_y;
    last_d       = last_q;
    step_count_d = step_count;
    ok_d         = ok;
    err_d        = err;
    err_code_d   = err_code;
    move_ready   = (state == ST_ACCEPT);
    rd_en        = 1'b0;

    // A start pulse wins over any handshake in the same cycle; that move is simply lost.
    if (start) begin
      state_d      = ST_ACCEPT;
      pos_x_d      = START_XV;
      pos_y_d      = START_YV;
      step_count_d = '0;
      ok_d         = 1'b0;
      err_d        = 1'b0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (move_valid) begin
            if (step_oob) begin
              state_d    = ST_FAIL;
              err_d      = 1'b1;
              err_code_d = ERR_OOB;
            end else begin
              rd_en   = 1'b1;
              nxt_x_d = step_x;
              nxt_y_d = step_y;
              last_d  = move_last;
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (rd_data == CELL_WALL) begin
            state_d    = ST_FAIL;
            err_d      = 1'b1;
            err_code_d = ERR_WALL;
          end else begin
            pos_x_d = nxt_x;
            pos_y_d = nxt_y;
            if (count_inc > MAX_EXT) begin
              step_count_d = MAX_SAT;
              state_d      = ST_FAIL;
              err_d        = 1'b1;
              err_code_d   = ERR_OVF;
            end else begin
              step_count_d = count_inc[STEP_W-1:0];
              if (last_q) begin
                if (nxt_x == GOAL_XV && nxt_y == GOAL_YV) begin
                  state_d = ST_PASS;
                  ok_d    = 1'b1;
                end else begin
                  state_d    = ST_FAIL;
                  err_d      = 1'b1;
                  err_code_d = ERR_NOGOAL;
                end
              end else begin
                state_d = ST_ACCEPT;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The read address is only meaningful alongside rd_en; it idles at zero otherwise.
  assign rd_x = rd_en ? step_x : '0;
  assign rd_y = rd_en ? step_y : '0;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pos_x      <= START_XV;
      pos_y      <= START_YV;
      nxt_x      <= '0;
      nxt_y      <= '0;
      last_q     <= 1'b0;
      step_count <= '0;
      ok         <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_OOB;
    end else begin
      state      <= state_d;
      pos_x      <= pos_x_d;
      pos_y      <= pos_y_d;
      nxt_x      <= nxt_x_d;
      nxt_y      <= nxt_y_d;
      last_q     <= last_d;
      step_count <= step_count_d;
      ok         <= ok_d;
      err        <= err_d;
      err_code   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_path_replay_checker.sv
// Bench for path_replay_checker: directed scenarios plus random mazes and paths, each
// judged against a walk-the-path reference model. Two instances: default and MAX_STEPS=4.
module tb_path_replay_checker;
  import maze_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s     [2];
  logic       mv_valid_s  [2];
  logic [1:0] mv_s        [2];
  logic       mv_last_s   [2];
  logic       move_ready_s[2];
  logic       rd_en_s     [2];
  logic [3:0] rd_x_s      [2];
  logic [3:0] rd_y_s      [2];
  logic       rd_data_s   [2];
  logic [3:0] pos_x_s     [2];
  logic [3:0] pos_y_s     [2];
  logic [7:0] step_s      [2];
  logic       ok_s        [2];
  logic       err_s       [2];
  logic [1:0] err_code_s  [2];

  bit maze[16][16];
  int rd_cnt [2];
  int last_rx[2];
  int last_ry[2];
  int mv_q[$];

  int total = 0;
  int bad   = 0;

  path_replay_checker u_big (
    .clk(clk), .rst(rst), .start(start_s[0]), .move_valid(mv_valid_s[0]), .move(mv_s[0]),
    .move_last(mv_last_s[0]), .move_ready(move_ready_s[0]), .rd_en(rd_en_s[0]),
    .rd_x(rd_x_s[0]), .rd_y(rd_y_s[0]), .rd_data(rd_data_s[0]), .pos_x(pos_x_s[0]),
    .pos_y(pos_y_s[0]), .step_count(step_s[0]), .ok(ok_s[0]), .err(err_s[0]),
    .err_code(err_code_s[0])
  );

  path_replay_checker #(.MAX_STEPS(4)) u_small (
    .clk(clk), .rst(rst), .start(start_s[1]), .move_valid(mv_valid_s[1]), .move(mv_s[1]),
    .move_last(mv_last_s[1]), .move_ready(move_ready_s[1]), .rd_en(rd_en_s[1]),
    .rd_x(rd_x_s[1]), .rd_y(rd_y_s[1]), .rd_data(rd_data_s[1]), .pos_x(pos_x_s[1]),
    .pos_y(pos_y_s[1]), .step_count(step_s[1]), .ok(ok_s[1]), .err(err_s[1]),
    .err_code(err_code_s[1])
  );

  // Maze memory with one-cycle read latency, plus a log of every read request.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rd_data_s[i] <= rd_en_s[i] ? maze[rd_y_s[i]][rd_x_s[i]] : 1'b0;
      if (rd_en_s[i]) begin
        rd_cnt[i]  <= rd_cnt[i] + 1;
        last_rx[i] <= int'(rd_x_s[i]);
        last_ry[i] <= int'(rd_y_s[i]);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: walk the path cell by cell and stop at the first rule that breaks.
  task automatic model(input int maxs, output int e_ok, output int e_err, output int e_code,
                       output int e_x, output int e_y, output int e_n, output int e_rd,
                       output int e_rx, output int e_ry);
    int x, y, nx, ny;
    x = 0; y = 0; e_n = 0; e_rd = 0; e_rx = 0; e_ry = 0;
    e_ok = 0; e_err = 0; e_code = 0;
    for (int i = 0; i < mv_q.size(); i++) begin
      nx = x + ((mv_q[i] == 1) ? 1 : (mv_q[i] == 2) ? -1 : 0);
      ny = y + ((mv_q[i] == 3) ? 1 : (mv_q[i] == 0) ? -1 : 0);
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
        e_err = 1; e_code = 0; break;
      end
      e_rd++; e_rx = nx; e_ry = ny;
      if (maze[ny][nx]) begin
        e_err = 1; e_code = 1; break;
      end
      x = nx; y = ny; e_n++;
      if (e_n > maxs) begin
        e_n = maxs; e_err = 1; e_code = 2; break;
      end
      if (i == mv_q.size() - 1) begin
        if (x == 15 && y == 15) e_ok = 1;
        else begin e_err = 1; e_code = 3; end
      end
    end
    e_x = x; e_y = y;
  endtask

  // Pulse start, then feed mv_q (last flag on the final entry). Returns idle cycles
  // spent waiting for move_ready between moves.
  task automatic run_path(input int sel, output int waits);
    int b;
    waits = 0;
    @(negedge clk); start_s[sel] = 1'b1;
    @(negedge clk); start_s[sel] = 1'b0;
    for (int i = 0; i < mv_q.size(); i++) begin
      b = 0;
      while (!move_ready_s[sel] && !ok_s[sel] && !err_s[sel] && b < 8) begin
        @(negedge clk); b++;
      end
      if (ok_s[sel] || err_s[sel]) break;
      if (b == 8) begin
        check("ready_timeout", int'(move_ready_s[sel]), 1);
        break;
      end
      waits += b;
      mv_valid_s[sel] = 1'b1;
      mv_s[sel]       = 2'(mv_q[i]);
      mv_last_s[sel]  = (i == mv_q.size() - 1);
      @(negedge clk);
      mv_valid_s[sel] = 1'b0;
      mv_last_s[sel]  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_path(input int sel, input string tag, output int waits);
    int rd0, e_ok, e_err, e_code, e_x, e_y, e_n, e_rd, e_rx, e_ry;
    rd0 = rd_cnt[sel];
    run_path(sel, waits);
    model(sel == 1 ? 4 : 255, e_ok, e_err, e_code, e_x, e_y, e_n, e_rd, e_rx, e_ry);
    check({tag, ".ok"},    int'(ok_s[sel]), e_ok);
    check({tag, ".err"},   int'(err_s[sel]), e_err);
    if (e_err == 1) check({tag, ".code"}, int'(err_code_s[sel]), e_code);
    check({tag, ".pos_x"}, int'(pos_x_s[sel]), e_x);
    check({tag, ".pos_y"}, int'(pos_y_s[sel]), e_y);
    check({tag, ".steps"}, int'(step_s[sel]), e_n);
    check({tag, ".reads"}, rd_cnt[sel] - rd0, e_rd);
    if (e_rd > 0) begin
      check({tag, ".rd_x"}, last_rx[sel], e_rx);
      check({tag, ".rd_y"}, last_ry[sel], e_ry);
    end
    check({tag, ".ready"}, int'(move_ready_s[sel]), 0);
  endtask

  task automatic check_reset(input int sel, input string tag);
    check({tag, ".ready"}, int'(move_ready_s[sel]), 0);
    check({tag, ".rd_en"}, int'(rd_en_s[sel]), 0);
    check({tag, ".rd_xy"}, int'({rd_x_s[sel], rd_y_s[sel]}), 0);
    check({tag, ".ok"},    int'(ok_s[sel]), 0);
    check({tag, ".err"},   int'(err_s[sel]), 0);
    check({tag, ".code"},  int'(err_code_s[sel]), 0);
    check({tag, ".steps"}, int'(step_s[sel]), 0);
    check({tag, ".pos"},   int'({pos_x_s[sel], pos_y_s[sel]}), 0);
  endtask

  task automatic clear_maze();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) maze[y][x] = 1'b0;
  endtask

  initial begin
    int w, rd0, sel, len;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; mv_valid_s[i] = 1'b0; mv_s[i] = 2'b00; mv_last_s[i] = 1'b0;
    end
    clear_maze();
    repeat (3) @(negedge clk);
    check_reset(0, "reset0");
    check_reset(1, "reset1");
    rst = 1'b1;

    // Wall-free diagonal-corner path: 15 right then 15 down.
    mv_q.delete();
    for (int i = 0; i < 15; i++) mv_q.push_back(MV_RIGHT);
    for (int i = 0; i < 15; i++) mv_q.push_back(MV_DOWN);
    do_path(0, "t1", w);
    check("t1.waits", w, 29);
    mv_valid_s[0] = 1'b1; mv_s[0] = MV_UP;
    repeat (3) @(negedge clk);
    mv_valid_s[0] = 1'b0;
    check("t1.hold_ok", int'(ok_s[0]), 1);
    check("t1.hold_pos", int'({pos_x_s[0], pos_y_s[0]}), 8'hFF);

    mv_q.delete(); mv_q.push_back(MV_UP);
    do_path(0, "t2", w);

    maze[0][1] = 1'b1;
    mv_q.delete(); mv_q.push_back(MV_RIGHT);
    do_path(0, "t3", w);
    clear_maze();

    mv_q.delete(); mv_q.push_back(MV_RIGHT); mv_q.push_back(MV_RIGHT); mv_q.push_back(MV_DOWN);
    do_path(0, "t4", w);

    mv_q.delete();
    for (int i = 0; i < 5; i++) mv_q.push_back((i % 2 == 0) ? MV_RIGHT : MV_LEFT);
    do_path(1, "t5", w);

    // Reset while the first move is being checked, then moves offered in IDLE.
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0; mv_valid_s[0] = 1'b1; mv_s[0] = MV_RIGHT;
    @(negedge clk); mv_valid_s[0] = 1'b0; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_reset(0, "t6rst");
    rd0 = rd_cnt[0];
    mv_valid_s[0] = 1'b1; mv_s[0] = MV_DOWN;
    repeat (3) @(negedge clk);
    mv_valid_s[0] = 1'b0;
    check("t6idle.reads", rd_cnt[0] - rd0, 0);
    check("t6idle.steps", int'(step_s[0]), 0);
    check("t6idle.ready", int'(move_ready_s[0]), 0);

    // Start colliding with a handshake in ACCEPT drops the move.
    rd0 = rd_cnt[0];
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0; mv_valid_s[0] = 1'b1; mv_s[0] = MV_RIGHT;
    @(negedge clk); mv_valid_s[0] = 1'b0;
    @(negedge clk); check("t6s.ready1", int'(move_ready_s[0]), 1);
    start_s[0] = 1'b1; mv_valid_s[0] = 1'b1; mv_s[0] = MV_DOWN;
    @(negedge clk); start_s[0] = 1'b0; mv_valid_s[0] = 1'b0;
    check("t6s.pos", int'({pos_x_s[0], pos_y_s[0]}), 0);
    check("t6s.steps", int'(step_s[0]), 0);
    check("t6s.ready2", int'(move_ready_s[0]), 1);
    @(negedge clk);
    check("t6s.reads", rd_cnt[0] - rd0, 1);
    check("t6s.pos2", int'({pos_x_s[0], pos_y_s[0]}), 0);

    // Random mazes and paths on both instances.
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 1));
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) maze[y][x] = ($urandom_range(0, 99) < 12);
      maze[0][0] = 1'b0;
      len = int'($urandom_range(1, 12));
      mv_q.delete();
      for (int i = 0; i < len; i++)
        mv_q.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3) == 3 ? 3 : 1)
                                                    : int'($urandom_range(0, 3)));
      do_path(sel, $sformatf("rnd%0d", t), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
